// File: rtl/mod_exp_if.sv
// -----------------------------------------------------------------------------
// mod_exp_if
// Request/result bundle of the modular exponentiator.
//   start  master->slave  request, sampled only while the engine is idle
//   base   master->slave  base value, captured on an accepted start
//   e      master->slave  exponent, captured on an accepted start
//   p      master->slave  modulus, captured on an accepted start
//   busy   slave->master  high from the cycle after accept until done
//   done   slave->master  one-cycle result pulse
//   st     slave->master  result-valid level, high from done until next accept
//   exp    slave->master  {WIDTH'b0, result}
//   err    slave->master  modulus was zero; held alongside st
// -----------------------------------------------------------------------------
interface mod_exp_if #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 32
);
  logic               start;
  logic [WIDTH-1:0]   base;
  logic [EXP_W-1:0]   e;
  logic [WIDTH-1:0]   p;
  logic               busy;
  logic               done;
  logic               st;
  logic [2*WIDTH-1:0] exp;
  logic               err;

  modport master (
    output start, base, e, p,
    input  busy, done, st, exp, err
  );

  modport slave (
    input  start, base, e, p,
    output busy, done, st, exp, err
  );
endinterface

// File: rtl/mod_exp_engine.sv
// -----------------------------------------------------------------------------
// mod_exp_engine
// Iterative modular exponentiator: res = base^e mod p, square-and-multiply,
// exponent scanned MSB first over all EXP_W bits (leading zeros included).
// Every modular operation is one WIDTH x WIDTH multiply cycle followed by
// 2*WIDTH cycles of restoring reduction, so the result is always < p.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   mod_exp_if.slave (start/base/e/p in, busy/done/st/exp/err out)
//
// Configuration macro
//   MODEXP_CONST_TIME_EN  when defined, the multiply step runs for every
//                         exponent bit and its result is dropped for 0 bits,
//                         making latency independent of e.
// -----------------------------------------------------------------------------
module mod_exp_engine #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mod_exp_if.slave  bus
);

`ifdef MODEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BRED, S_SQR, S_MUL, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Result-side registers (reset)
  logic               st_q, err_q;
  logic [2*WIDTH-1:0] exp_q;

  // Datapath registers (not reset)
  logic [WIDTH-1:0]   base_q, p_q, acc_q, acc_d, b_q, r_q;
  logic [EXP_W-1:0]   e_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               phase_q;   // 0: multiply cycle, 1: reduction cycles

  logic               op_last, cur_bit, idx_zero, finish;
  logic [WIDTH:0]     r_shift, r_diff;
  logic [WIDTH-1:0]   r_next;

  assign op_last  = phase_q && (cnt_q == CNT_LAST);
  assign cur_bit  = e_q[idx_q];
  assign idx_zero = (idx_q == '0);

  // Restoring reduce step. r_q < p, so r_shift < 2p and the sign bit of
  // r_shift - p tells whether the subtraction is taken.
  assign r_shift = {r_q, prod_q[2*WIDTH-1]};
  assign r_diff  = r_shift - {1'b0, p_q};
  assign r_next  = r_diff[WIDTH] ? r_shift[WIDTH-1:0] : r_diff[WIDTH-1:0];

  always_comb begin
    if (state_q == S_BRED)
      prod_d = {{WIDTH{1'b0}}, base_q};
    else if (state_q == S_MUL)
      prod_d = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b_q};
    else
      prod_d = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, acc_q};
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: state_d = (p_q == '0) ? S_DONE : S_BRED;
      S_BRED: if (op_last) state_d = S_SQR;
      S_SQR:  if (op_last)
                state_d = (CONST_TIME || cur_bit) ? S_MUL
                                                  : (idx_zero ? S_DONE : S_SQR);
      S_MUL:  if (op_last) state_d = idx_zero ? S_DONE : S_SQR;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done = (state_q == S_DONE);
    bus.st   = st_q;
    bus.err  = err_q;
    bus.exp  = exp_q;
  end

  // Accumulator update; a multiply on a 0 bit (const-time only) is dropped.
  always_comb begin
    acc_d = acc_q;
    case (state_q)
      S_LOAD: acc_d = WIDTH'(1);
      S_SQR:  if (op_last) acc_d = r_next;
      S_MUL:  if (op_last && cur_bit) acc_d = r_next;
      default: ;
    endcase
  end

  assign finish = ((state_q == S_SQR) || (state_q == S_MUL)) && (state_d == S_DONE);

  // Result registers are loaded on the edge into DONE so they are already
  // valid in the cycle that done pulses.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= 1'b0;
      err_q <= 1'b0;
      exp_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      st_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q == S_LOAD && p_q == '0) begin
      st_q  <= 1'b1;
      err_q <= 1'b1;
      exp_q <= '0;
    end else if (finish) begin
      st_q  <= 1'b1;
      exp_q <= {{WIDTH{1'b0}}, acc_d};
    end
  end

  // NOTE: the datapath carries no reset; every field is (re)initialised on
  // accept or in LOAD before it is read, so resetting it only costs logic.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    case (state_q)
      S_IDLE: if (bus.start) begin
        base_q <= bus.base;
        e_q    <= bus.e;
        p_q    <= bus.p;
      end
      S_LOAD: begin
        phase_q <= 1'b0;
        idx_q   <= IDX_TOP;
      end
      S_BRED, S_SQR, S_MUL: begin
        if (!phase_q) begin
          prod_q  <= prod_d;
          r_q     <= '0;
          cnt_q   <= '0;
          phase_q <= 1'b1;
        end else begin
          prod_q <= prod_q << 1;
          r_q    <= r_next;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            phase_q <= 1'b0;
            if (state_q == S_BRED) b_q <= r_next;
            // Move to the next exponent bit whenever the next op is a square.
            if (state_q != S_BRED && state_d == S_SQR) idx_q <= idx_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_engine
// Directed bench for mod_exp_engine with hand-computed results and latencies.
// Builds with or without MODEXP_CONST_TIME_EN; expected latency follows the
// selected build.
// -----------------------------------------------------------------------------
module tb_mod_exp_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_exp_if #(.WIDTH(32), .EXP_W(32)) bus ();

  mod_exp_engine #(.WIDTH(32), .EXP_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int BUDGET = 6000;

  // Accept cycle = 0; done at 2 + (1+K)*65.
  function automatic int exp_lat(input logic [31:0] ev);
`ifdef MODEXP_CONST_TIME_EN
    return 4227;
`else
    return 2 + (1 + 32 + $countones(ev)) * 65;
`endif
  endfunction

  // Issue one request and wait for done. Returns the cycle done was seen
  // (-1 on timeout), outputs in that cycle and st/busy in cycle 1.
  // A nonzero pulse_cyc raises start with junk operands for one mid-run cycle.
  task automatic run_op(input logic [31:0] b, input logic [31:0] ev,
                        input logic [31:0] pv, input int pulse_cyc,
                        output int lat, output logic [63:0] r,
                        output logic er, output logic st_c1,
                        output logic busy_c1);
    int cyc;
    @(posedge clk); #1;
    bus.base = b; bus.e = ev; bus.p = pv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    st_c1 = bus.st;
    busy_c1 = bus.busy;
    while (!bus.done && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == pulse_cyc) begin
        bus.base = 32'd7; bus.e = 32'd3; bus.p = 32'd11; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    lat = bus.done ? cyc : -1;
    r   = bus.exp;
    er  = bus.err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.e = '0; bus.p = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.st !== 1'b0) begin errors++; $display("FAIL reset_st got %b want 0", bus.st); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.exp !== 64'd0) begin errors++; $display("FAIL reset_exp got %0h want 0", bus.exp); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [63:0] r; logic er, s1, b1;
    run_op(32'd5, 32'd6, 32'd23, 0, lat, r, er, s1, b1);
    checks++; if (r !== 64'd8) begin errors++; $display("FAIL basic_exp got %0d want 8", r); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", er); end
    checks++; if (lat !== exp_lat(32'd6)) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(32'd6)); end
    checks++; if (s1 !== 1'b0 || b1 !== 1'b1) begin errors++; $display("FAIL basic_cycle1 got st=%b busy=%b want st=0 busy=1", s1, b1); end
    checks++; if (bus.st !== 1'b1) begin errors++; $display("FAIL basic_st_at_done got %b want 1", bus.st); end
    @(posedge clk); #1;
    checks++; if (bus.st !== 1'b1 || bus.done !== 1'b0 || bus.exp !== 64'd8) begin
      errors++; $display("FAIL basic_hold got st=%b done=%b exp=%0d want st=1 done=0 exp=8", bus.st, bus.done, bus.exp);
    end
  endtask

  typedef struct {
    logic [31:0] b, ev, pv;
    logic [63:0] res;
  } vec_t;

  task automatic test_vectors();
    vec_t v[5];
    int lat; logic [63:0] r; logic er, s1, b1;
    v[0] = '{32'd100,        32'd1, 32'd7,          64'd2}; // base >= p
    v[1] = '{32'hFFFF_FFFE,  32'd2, 32'hFFFF_FFFB,  64'd9}; // full-width carry
    v[2] = '{32'd5,          32'd0, 32'd23,         64'd1}; // e == 0
    v[3] = '{32'd5,          32'd0, 32'd1,          64'd0}; // p == 1
    v[4] = '{32'd0,          32'd5, 32'd23,         64'd0}; // base == 0
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].b, v[i].ev, v[i].pv, 0, lat, r, er, s1, b1);
      checks++; if (r !== v[i].res) begin errors++; $display("FAIL vec%0d_exp got %0d want %0d", i, r, v[i].res); end
      checks++; if (lat !== exp_lat(v[i].ev)) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, exp_lat(v[i].ev)); end
    end
  endtask

  task automatic test_p_zero();
    int lat; logic [63:0] r; logic er, s1, b1;
    run_op(32'd5, 32'd6, 32'd0, 0, lat, r, er, s1, b1);
    checks++; if (lat !== 2) begin errors++; $display("FAIL pzero_latency got %0d want 2", lat); end
    checks++; if (r !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL pzero_result got exp=%0d err=%b want exp=0 err=1", r, er); end
    run_op(32'd5, 32'd6, 32'd23, 0, lat, r, er, s1, b1);
    checks++; if (er !== 1'b0 || r !== 64'd8) begin errors++; $display("FAIL pzero_clear got exp=%0d err=%b want exp=8 err=0", r, er); end
  endtask

  task automatic test_mid_start();
    int lat; logic [63:0] r; logic er, s1, b1;
    run_op(32'd5, 32'd6, 32'd23, 500, lat, r, er, s1, b1);
    checks++; if (r !== 64'd8 || lat !== exp_lat(32'd6)) begin
      errors++; $display("FAIL mid_start got exp=%0d lat=%0d want exp=8 lat=%0d", r, lat, exp_lat(32'd6));
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    n = exp_lat(32'd1);
    @(posedge clk); #1;
    bus.base = 32'd100; bus.e = 32'd1; bus.p = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!bus.done && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
    checks++; if (!bus.done || cyc != n) begin errors++; $display("FAIL b2b_first got lat=%0d want %0d", cyc, n); end
    @(posedge clk); #1; cyc++;
    checks++; if (bus.busy !== 1'b0 || bus.st !== 1'b1) begin errors++; $display("FAIL b2b_idle got busy=%b st=%b want busy=0 st=1", bus.busy, bus.st); end
    @(posedge clk); #1; cyc++;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.st !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy=%b st=%b want busy=1 st=0", bus.busy, bus.st); end
    while (!bus.done && cyc < 2 * BUDGET) begin @(posedge clk); #1; cyc++; end
    checks++; if (!bus.done || cyc != 2 * n + 1 || bus.exp !== 64'd2) begin
      errors++; $display("FAIL b2b_second got lat=%0d exp=%0d want lat=%0d exp=2", cyc, bus.exp, 2 * n + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [63:0] r; logic er, s1, b1;
    @(posedge clk); #1;
    bus.base = 32'd5; bus.e = 32'd6; bus.p = 32'd23; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.st !== 1'b0 || bus.err !== 1'b0 || bus.exp !== 64'd0) begin
      errors++; $display("FAIL rstmid_out got st=%b err=%b exp=%0d want 0 0 0", bus.st, bus.err, bus.exp);
    end
    rst = 1'b1;
    run_op(32'd100, 32'd1, 32'd7, 0, lat, r, er, s1, b1);
    checks++; if (r !== 64'd2 || lat !== exp_lat(32'd1)) begin
      errors++; $display("FAIL rstmid_after got exp=%0d lat=%0d want exp=2 lat=%0d", r, lat, exp_lat(32'd1));
    end
  endtask

  task automatic test_const_time();
    int lat; logic [63:0] r; logic er, s1, b1;
    // 5^(2^32-1) mod 23: order of 5 divides 22 and 2^32-1 = 3 mod 22 -> 125 mod 23 = 10
    run_op(32'd5, 32'd1, 32'd23, 0, lat, r, er, s1, b1);
    checks++; if (r !== 64'd5 || lat !== exp_lat(32'd1)) begin
      errors++; $display("FAIL ct_e1 got exp=%0d lat=%0d want exp=5 lat=%0d", r, lat, exp_lat(32'd1));
    end
    run_op(32'd5, 32'hFFFF_FFFF, 32'd23, 0, lat, r, er, s1, b1);
    checks++; if (r !== 64'd10 || lat !== 4227) begin
      errors++; $display("FAIL ct_eall got exp=%0d lat=%0d want exp=10 lat=4227", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_p_zero();
    test_mid_start();
    test_back_to_back();
    test_reset_mid_run();
    test_const_time();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
